seg7_scan_decoder: RTL and testbench

- Reverse direction of the hex-to-segment display path. Samples a multiplexed, active-low 7-segment bus (segments plus per-digit enables), validates each pattern, and recovers the hex nibble shown on every digit.
- Used as an on-chip display monitor and readback block for the vending machine front panel, e.g. for self-test comparison against the credit and price registers.
- Inputs may come from pins and are treated as asynchronous.

---
 rtl/seg7_scan_decoder.sv | 259 +++++++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// ----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Purpose:
//    Display monitor for a multiplexed, active-low 7-segment bus. It watches
//    the segment lines and the per-digit anode enables, waits for a pattern to
//    settle, checks it, and recovers the hex nibble shown on every digit, so
//    firmware can read back what the front panel is showing.
//
// Ports:
//    i_clk      system clock
//    i_rst_n    asynchronous active-low reset
//    i_seg      segment bus [6:0], low = segment lit (asynchronous input)
//    i_an       digit enables, low = digit active, bit k = digit k (async)
//    i_clr      synchronous clear of the error flags and the frame mask
//    o_digits   decoded nibbles, digit k in [4k+3:4k]
//    o_valid    digit k holds a legal decoded hex value
//    o_blank    digit k was last seen blank (all segments off)
//    o_err      sticky flags: [0] illegal pattern, [1] anode conflict
//    o_upd      one-cycle pulse when any digit/valid/blank bit changes
//    o_frame    one-cycle pulse once every digit has been captured
//    o_stale    no capture for TIMEOUT cycles
// ----------------------------------------------------------------------------
module seg7_scan_decoder #(
   parameter int N_DIGITS = 4,
   parameter int STABLE   = 4,
   parameter int TIMEOUT  = 1000000
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [6:0]              i_seg,
   input  logic [N_DIGITS-1:0]     i_an,
   input  logic                    i_clr,
   output logic [4*N_DIGITS-1:0]   o_digits,
   output logic [N_DIGITS-1:0]     o_valid,
   output logic [N_DIGITS-1:0]     o_blank,
   output logic [1:0]              o_err,
   output logic                    o_upd,
   output logic                    o_frame,
   output logic                    o_stale
);

   localparam int SW = N_DIGITS + 7;
   localparam int CW = $clog2(STABLE);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] CNT_ARM = CW'(STABLE - 2);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE - 1);
   localparam logic [TW-1:0] TO_ARM  = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
   localparam logic [6:0]    SEG_BLANK = 7'b1111111;

   // Segment pattern to {hit, nibble}. Anything not in the table is a miss.
   function automatic logic [4:0] f_decode(input logic [6:0] seg);
      logic [4:0] res;
      res = 5'b0_0000;
      case (seg)
         7'b1000000: res = 5'h10;
         7'b1111001: res = 5'h11;
         7'b0100100: res = 5'h12;
         7'b0110000: res = 5'h13;
         7'b0011001: res = 5'h14;
         7'b0010010: res = 5'h15;
         7'b0000010: res = 5'h16;
         7'b1111000: res = 5'h17;
         7'b0000000: res = 5'h18;
         7'b0010000: res = 5'h19;
         7'b0001000: res = 5'h1A;
         7'b0000011: res = 5'h1B;
         7'b0100111: res = 5'h1C;
         7'b0100001: res = 5'h1D;
         7'b0000110: res = 5'h1E;
         7'b0001110: res = 5'h1F;
         default:    res = 5'h00;
      endcase
      return res;
   endfunction

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [6:0]              r_seg_s1, r_seg_s2;
   logic [N_DIGITS-1:0]     r_an_s1, r_an_s2;
   logic [SW-1:0]           r_prev;
   logic [CW-1:0]           r_cnt;
   logic [TW-1:0]           r_tcnt;
   logic [4*N_DIGITS-1:0]   r_digits;
   logic [N_DIGITS-1:0]     r_valid;
   logic [N_DIGITS-1:0]     r_blank;
   logic [N_DIGITS-1:0]     r_mask;
   logic [1:0]              r_err;
   logic                    r_upd;
   logic                    r_frame;
   logic                    r_stale;

   // ------------------------------------------------------------------------
   // Combinational datapath
   // ------------------------------------------------------------------------
   logic [SW-1:0]           w_samp;
   logic                    w_same;
   logic                    w_cap;
   logic [N_DIGITS-1:0]     w_low;
   logic [N_DIGITS-1:0]     w_low_m1;
   logic                    w_onehot;
   logic                    w_conflict;
   logic                    w_take;
   logic [4:0]              w_dec;
   logic                    w_hit;
   logic [3:0]              w_nib;
   logic                    w_is_blank;
   logic                    w_illegal;
   logic                    w_to_hit;
   logic                    w_mask_full;
   logic [N_DIGITS-1:0]     w_mask_next;
   logic [1:0]              w_err_next;
   logic [4*N_DIGITS-1:0]   w_digits_next;
   logic [N_DIGITS-1:0]     w_valid_next;
   logic [N_DIGITS-1:0]     w_blank_next;
   logic                    w_change;

   assign w_samp = {r_an_s2, r_seg_s2};
   assign w_same = (w_samp == r_prev);

   // The counter passes through CNT_ARM exactly once per dwell because it
   // saturates at CNT_MAX, so this fires a single capture per dwell.
   assign w_cap = w_same && (r_cnt == CNT_ARM);

   // Active digits as a high-true vector; x & (x-1) == 0 means at most one bit.
   assign w_low      = ~r_an_s2;
   assign w_low_m1   = w_low - N_DIGITS'(1);
   assign w_onehot   = (|w_low) && !(|(w_low & w_low_m1));
   assign w_conflict = w_cap && (|w_low) && !w_onehot;
   assign w_take     = w_cap && w_onehot;

   assign w_dec      = f_decode(r_seg_s2);
   assign w_hit      = w_dec[4];
   assign w_nib      = w_dec[3:0];
   assign w_is_blank = (r_seg_s2 == SEG_BLANK);
   assign w_illegal  = w_take && !w_hit && !w_is_blank;

   // Timeout fires on the cycle the counter would reach TIMEOUT; a capture in
   // the same cycle takes priority and restarts the count instead.
   assign w_to_hit   = !w_take && (r_tcnt == TO_ARM);

   // A full mask is consumed (frame pulse + clear) one cycle after it fills.
   // Clear sources wipe the old mask first, then the current capture is ORed
   // in, so a capture coinciding with i_clr leaves just its own bit set.
   assign w_mask_full = &r_mask;
   assign w_mask_next = ((w_mask_full || i_clr || w_to_hit) ? '0 : r_mask)
                      | (w_take ? w_low : '0);

   // Newly detected errors are ORed after the clear so they survive i_clr.
   assign w_err_next  = (i_clr ? 2'b00 : r_err) | {w_conflict, w_illegal};

   // Per-digit next state; only the single selected digit can change on a
   // capture, while a timeout drops every valid bit at once.
   generate
      for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
         logic w_sel;
         assign w_sel = w_take && w_low[gi];

         assign w_digits_next[4*gi +: 4] = (w_sel && w_hit) ? w_nib
                                                            : r_digits[4*gi +: 4];

         assign w_valid_next[gi] = w_to_hit ? 1'b0
                                 : w_sel    ? w_hit
                                 :            r_valid[gi];

         assign w_blank_next[gi] = (w_sel && w_hit)      ? 1'b0
                                 : (w_sel && w_is_blank) ? 1'b1
                                 :                         r_blank[gi];
      end
   endgenerate

   assign w_change = (w_digits_next != r_digits)
                  || (w_valid_next != r_valid)
                  || (w_blank_next != r_blank);

   // ------------------------------------------------------------------------
   // Input synchronizers (pins are asynchronous to i_clk)
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_seg_s1 <= '0;
         r_seg_s2 <= '0;
         r_an_s1  <= '0;
         r_an_s2  <= '0;
      end else begin
         r_seg_s1 <= i_seg;
         r_seg_s2 <= r_seg_s1;
         r_an_s1  <= i_an;
         r_an_s2  <= r_an_s1;
      end
   end

   // ------------------------------------------------------------------------
   // Stability and timeout counters
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev <= '0;
         r_cnt  <= '0;
         r_tcnt <= '0;
      end else begin
         r_prev <= w_samp;

         if (!w_same) begin
            r_cnt <= '0;
         end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
         end

         if (w_take) begin
            r_tcnt <= '0;
         end else if (r_tcnt != TO_MAX) begin
            r_tcnt <= r_tcnt + TW'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Decoded digit state and status
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_digits <= '0;
         r_valid  <= '0;
         r_blank  <= '0;
         r_mask   <= '0;
         r_err    <= '0;
         r_upd    <= 1'b0;
         r_frame  <= 1'b0;
         r_stale  <= 1'b0;
      end else begin
         r_digits <= w_digits_next;
         r_valid  <= w_valid_next;
         r_blank  <= w_blank_next;
         r_mask   <= w_mask_next;
         r_err    <= w_err_next;
         r_upd    <= w_change;
         r_frame  <= w_mask_full;

         if (w_take) begin
            r_stale <= 1'b0;
         end else if (w_to_hit) begin
            r_stale <= 1'b1;
         end
      end
   end

   assign o_digits = r_digits;
   assign o_valid  = r_valid;
   assign o_blank  = r_blank;
   assign o_err    = r_err;
   assign o_upd    = r_upd;
   assign o_frame  = r_frame;
   assign o_stale  = r_stale;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Directed bench for seg7_scan_decoder (N_DIGITS=4, STABLE=4, TIMEOUT=64).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

   localparam int N_DIGITS = 4;
   localparam int STABLE   = 4;
   localparam int TIMEOUT  = 64;

   logic                  clk;
   logic                  i_rst_n;
   logic [6:0]            i_seg;
   logic [N_DIGITS-1:0]   i_an;
   logic                  i_clr;
   logic [4*N_DIGITS-1:0] o_digits;
   logic [N_DIGITS-1:0]   o_valid;
   logic [N_DIGITS-1:0]   o_blank;
   logic [1:0]            o_err;
   logic                  o_upd;
   logic                  o_frame;
   logic                  o_stale;

   seg7_scan_decoder #(
      .N_DIGITS (N_DIGITS),
      .STABLE   (STABLE),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (i_rst_n),
      .i_seg    (i_seg),
      .i_an     (i_an),
      .i_clr    (i_clr),
      .o_digits (o_digits),
      .o_valid  (o_valid),
      .o_blank  (o_blank),
      .o_err    (o_err),
      .o_upd    (o_upd),
      .o_frame  (o_frame),
      .o_stale  (o_stale)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        clr;
      int          dwell;
      logic [15:0] e_digits;
      logic [3:0]  e_valid;
      logic [3:0]  e_blank;
      logic [1:0]  e_err;
      int          e_upd;
      int          e_frame;
   } vec_t;

   localparam int N_VEC = 18;
   localparam int N_A   = 15;   // vectors before the clear-during-capture case

   vec_t vecs [N_VEC];

   int n_total = 0;
   int n_pass  = 0;
   int upd_cnt;
   int frm_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      v = vecs[i];
      i_an  = v.an;
      i_seg = v.seg;
      i_clr = v.clr;
      upd_cnt = 0;
      frm_cnt = 0;
      for (int c = 1; c <= v.dwell; c++) begin
         @(negedge clk);
         upd_cnt += int'(o_upd);
         frm_cnt += int'(o_frame);
         i_clr = 1'b0;
      end
      chk($sformatf("v%0d digits", i), 32'(o_digits), 32'(v.e_digits));
      chk($sformatf("v%0d valid", i),  32'(o_valid),  32'(v.e_valid));
      chk($sformatf("v%0d blank", i),  32'(o_blank),  32'(v.e_blank));
      chk($sformatf("v%0d err", i),    32'(o_err),    32'(v.e_err));
      chk($sformatf("v%0d upd_pulses", i),   32'(upd_cnt), 32'(v.e_upd));
      chk($sformatf("v%0d frame_pulses", i), 32'(frm_cnt), 32'(v.e_frame));
      chk($sformatf("v%0d stale", i),  32'(o_stale),  32'd0);
      $display("vec %0d an=%b seg=%b clr=%b -> digits=%h valid=%b blank=%b err=%b upd=%0d frame=%0d",
               i, v.an, v.seg, v.clr, o_digits, o_valid, o_blank, o_err, upd_cnt, frm_cnt);
   endtask

   // Safety net: the test is bounded by clock counts, this only guards hangs.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100us");
      $fatal(1, "watchdog");
   end

   initial begin
      // an,    seg,        clr, dwell, digits,  valid,   blank,   err,  upd, frame
      // Scan digits 0..3 with 1,2,3,4
      vecs[0]  = '{4'b1110, 7'b1111001, 1'b0, 8, 16'h0001, 4'b0001, 4'b0000, 2'b00, 1, 0};
      vecs[1]  = '{4'b1101, 7'b0100100, 1'b0, 8, 16'h0021, 4'b0011, 4'b0000, 2'b00, 1, 0};
      vecs[2]  = '{4'b1011, 7'b0110000, 1'b0, 8, 16'h0321, 4'b0111, 4'b0000, 2'b00, 1, 0};
      vecs[3]  = '{4'b0111, 7'b0011001, 1'b0, 8, 16'h4321, 4'b1111, 4'b0000, 2'b00, 1, 1};
      // Same scan again: frame but no update
      vecs[4]  = '{4'b1110, 7'b1111001, 1'b0, 8, 16'h4321, 4'b1111, 4'b0000, 2'b00, 0, 0};
      vecs[5]  = '{4'b1101, 7'b0100100, 1'b0, 8, 16'h4321, 4'b1111, 4'b0000, 2'b00, 0, 0};
      vecs[6]  = '{4'b1011, 7'b0110000, 1'b0, 8, 16'h4321, 4'b1111, 4'b0000, 2'b00, 0, 0};
      vecs[7]  = '{4'b0111, 7'b0011001, 1'b0, 8, 16'h4321, 4'b1111, 4'b0000, 2'b00, 0, 1};
      // Glitch shorter than STABLE, then all anodes off
      vecs[8]  = '{4'b1101, 7'b0110000, 1'b0, 3, 16'h4321, 4'b1111, 4'b0000, 2'b00, 0, 0};
      vecs[9]  = '{4'b1111, 7'b0110000, 1'b0, 8, 16'h4321, 4'b1111, 4'b0000, 2'b00, 0, 0};
      // Illegal pattern, anode conflict, clear, blank
      vecs[10] = '{4'b1011, 7'b0101010, 1'b0, 8, 16'h4321, 4'b1011, 4'b0000, 2'b01, 1, 0};
      vecs[11] = '{4'b1100, 7'b0101010, 1'b0, 8, 16'h4321, 4'b1011, 4'b0000, 2'b11, 0, 0};
      vecs[12] = '{4'b1111, 7'b1111111, 1'b1, 8, 16'h4321, 4'b1011, 4'b0000, 2'b00, 0, 0};
      vecs[13] = '{4'b1011, 7'b1111111, 1'b0, 8, 16'h4321, 4'b1011, 4'b0100, 2'b00, 1, 0};
      vecs[14] = '{4'b0011, 7'b1111111, 1'b0, 8, 16'h4321, 4'b1011, 4'b0100, 2'b10, 0, 0};
      // After clear-during-capture: mask holds only digit 0
      vecs[15] = '{4'b1101, 7'b0100100, 1'b0, 8, 16'h4321, 4'b1010, 4'b0100, 2'b01, 0, 0};
      vecs[16] = '{4'b0111, 7'b0011001, 1'b0, 8, 16'h4321, 4'b1010, 4'b0100, 2'b01, 0, 0};
      vecs[17] = '{4'b1011, 7'b0001000, 1'b0, 8, 16'h4A21, 4'b1110, 4'b0000, 2'b01, 1, 1};

      // ---------------- Reset and timeout ----------------
      i_rst_n = 1'b0;
      i_an    = 4'b1111;
      i_seg   = 7'b1111111;
      i_clr   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst digits", 32'(o_digits), 32'd0);
      chk("rst valid",  32'(o_valid),  32'd0);
      chk("rst blank",  32'(o_blank),  32'd0);
      chk("rst err",    32'(o_err),    32'd0);
      chk("rst upd",    32'(o_upd),    32'd0);
      chk("rst frame",  32'(o_frame),  32'd0);
      chk("rst stale",  32'(o_stale),  32'd0);
      $display("reset: digits=%h valid=%b err=%b stale=%b", o_digits, o_valid, o_err, o_stale);

      i_rst_n = 1'b1;
      upd_cnt = 0;
      frm_cnt = 0;
      for (int c = 1; c <= TIMEOUT; c++) begin
         @(negedge clk);
         upd_cnt += int'(o_upd);
         frm_cnt += int'(o_frame);
         if (c == TIMEOUT - 1) chk("stale before timeout", 32'(o_stale), 32'd0);
         if (c == TIMEOUT)     chk("stale at timeout",     32'(o_stale), 32'd1);
      end
      chk("idle digits", 32'(o_digits), 32'd0);
      chk("idle err",    32'(o_err),    32'd0);
      chk("idle upd_pulses",   32'(upd_cnt), 32'd0);
      chk("idle frame_pulses", 32'(frm_cnt), 32'd0);
      $display("idle %0d cycles: stale=%b upd=%0d frame=%0d", TIMEOUT, o_stale, upd_cnt, frm_cnt);

      // ---------------- Capture latency on digit 0 ----------------
      i_an  = 4'b1110;
      i_seg = 7'b0100100;
      upd_cnt = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         upd_cnt += int'(o_upd);
         if (c == STABLE + 1) begin
            chk("lat valid early", 32'(o_valid), 32'd0);
            chk("lat stale early", 32'(o_stale), 32'd1);
         end
         if (c == STABLE + 2) begin
            chk("lat digit0", 32'(o_digits[3:0]), 32'd2);
            chk("lat valid",  32'(o_valid), 32'b0001);
            chk("lat upd",    32'(o_upd),   32'd1);
            chk("lat stale",  32'(o_stale), 32'd0);
         end
      end
      chk("lat upd_pulses", 32'(upd_cnt), 32'd1);
      $display("latency: digits=%h valid=%b upd=%0d", o_digits, o_valid, upd_cnt);

      // ---------------- Table: scan, glitch, errors, blank ----------------
      for (int i = 0; i < N_A; i++) run_vec(i);

      // ---------------- Clear coinciding with an illegal capture ----------------
      i_an  = 4'b1110;
      i_seg = 7'b0101010;
      upd_cnt = 0;
      frm_cnt = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         upd_cnt += int'(o_upd);
         frm_cnt += int'(o_frame);
         if (c == STABLE + 1) i_clr = 1'b1;
         if (c == STABLE + 2) begin
            i_clr = 1'b0;
            chk("clrcap err",   32'(o_err),   32'b01);
            chk("clrcap valid", 32'(o_valid), 32'b1010);
            chk("clrcap upd",   32'(o_upd),   32'd1);
         end
      end
      chk("clrcap frame_pulses", 32'(frm_cnt), 32'd0);
      $display("clear+capture: err=%b valid=%b upd=%0d", o_err, o_valid, upd_cnt);

      for (int i = N_A; i < N_VEC; i++) run_vec(i);

      // ---------------- Reset in the middle of a dwell ----------------
      i_an  = 4'b1110;
      i_seg = 7'b0000000;
      repeat (STABLE) @(negedge clk);
      i_rst_n = 1'b0;
      #1;
      chk("midrst digits", 32'(o_digits), 32'd0);
      chk("midrst valid",  32'(o_valid),  32'd0);
      chk("midrst err",    32'(o_err),    32'd0);
      chk("midrst stale",  32'(o_stale),  32'd0);
      repeat (2) @(negedge clk);
      chk("midrst held digits", 32'(o_digits), 32'd0);
      chk("midrst held upd",    32'(o_upd),    32'd0);
      i_rst_n = 1'b1;
      upd_cnt = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         upd_cnt += int'(o_upd);
         if (c == STABLE + 1) chk("postrst valid early", 32'(o_valid), 32'd0);
         if (c == STABLE + 2) begin
            chk("postrst digits", 32'(o_digits), 32'h0008);
            chk("postrst valid",  32'(o_valid),  32'b0001);
            chk("postrst upd",    32'(o_upd),    32'd1);
         end
      end
      chk("postrst upd_pulses", 32'(upd_cnt), 32'd1);
      $display("reset mid-dwell: digits=%h valid=%b upd=%0d", o_digits, o_valid, upd_cnt);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
